// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a load/store unit and data_mem_ctrl
interface data_mem_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [31:0] req_addr;
  logic [2:0] req_funct3;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I byte/half/word data memory with optional wait states
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic a_we;
  logic [31:0] a_addr, a_wd;
  logic [2:0] a_f3;
  logic s_we, bad_f3, err, go;
  logic [31:0] s_addr, s_wd, word, ld, wd_rep;
  logic [29:0] off_w;
  logic [2:0] s_f3;
  logic [1:0] lane;
  logic [AW-1:0] idx;
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  assign bus.req_ready = state == IDLE;
  // With no wait states the access happens on the accepting edge, so decode the live request in IDLE.
  always_comb begin
    s_we = state == IDLE ? bus.req_we : a_we;
    s_addr = state == IDLE ? bus.req_addr : a_addr;
    s_f3 = state == IDLE ? bus.req_funct3 : a_f3;
    s_wd = state == IDLE ? bus.req_wdata : a_wd;
    off_w = s_addr[31:2] - BASE_ADDR[31:2];
    lane = s_addr[1:0];
    idx = off_w[AW-1:0];
    word = mem[idx];
    b = 8'(word >> {lane, 3'b000});
    h = s_addr[1] ? word[31:16] : word[15:0];
    bad_f3 = s_we ? s_f3 > 3'd2 : (s_f3 == 3'd3 || s_f3[2:1] == 2'b11);
    err = bad_f3 || (s_f3[1:0] == 2'b01 && s_addr[0]) || (s_f3[1:0] == 2'b10 && lane != 2'd0)
          || s_addr < BASE_ADDR || {2'b00, off_w} >= 32'(DEPTH_WORDS);
    ld = s_f3 == 3'd0 ? {{24{b[7]}}, b} :
         s_f3 == 3'd1 ? {{16{h[15]}}, h} :
         s_f3 == 3'd4 ? {24'b0, b} :
         s_f3 == 3'd5 ? {16'b0, h} : word;
    be = s_f3[1] ? 4'hf : s_f3[0] ? (s_addr[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
    wd_rep = s_f3[1] ? s_wd : s_f3[0] ? {2{s_wd[15:0]}} : {4{s_wd[7:0]}};
    go = state == IDLE ? bus.req_valid && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0;
  end
  always_ff @(posedge clk)
    if (!reset && go && s_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.rsp_valid <= go;
      bus.rsp_rdata <= go && !err && !s_we ? ld : '0;
      bus.rsp_err <= go && err;
      case (state)
        IDLE: if (bus.req_valid) begin
          a_we <= bus.req_we;
          a_addr <= bus.req_addr;
          a_f3 <= bus.req_funct3;
          a_wd <= bus.req_wdata;
          state <= WAIT_CYCLES == 0 ? RESP : WAIT;
          cnt <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
        end
        WAIT: begin
          state <= cnt == 4'd0 ? RESP : WAIT;
          cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench for a zero-wait and a three-wait-state controller
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst0, rst3;
  always #5 clk = ~clk;
  data_mem_ctrl_if b0();
  data_mem_ctrl_if b3();
  data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) d0 (.clk(clk), .reset(rst0), .bus(b0.slave));
  data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) d3 (.clk(clk), .reset(rst3), .bus(b3.slave));
  typedef struct {
    logic [31:0] rd;
    logic err;
    int cyc;
    string name;
  } exp_t;
  exp_t q0[$], q3[$];
  exp_t e0, e3;
  int checks = 0, errors = 0, cyc = 0, low = 0;
  bit mon_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Responses are popped in order; latency is measured from the cycle the request was pushed.
  always @(negedge clk) if (mon_on) begin
    if (b0.rsp_valid) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0 unexpected response: rdata %h err %b", b0.rsp_rdata, b0.rsp_err);
      end else begin
        e0 = q0.pop_front();
        chk({"d0 ", e0.name, " rdata"}, b0.rsp_rdata, e0.rd);
        chk({"d0 ", e0.name, " err"}, 32'(b0.rsp_err), 32'(e0.err));
        chk({"d0 ", e0.name, " latency"}, 32'(cyc - e0.cyc), 32'd1);
      end
    end else chk("d0 idle outputs", b0.rsp_rdata | 32'(b0.rsp_err), 32'd0);
  end
  always @(negedge clk) if (mon_on) begin
    if (b3.rsp_valid) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL d3 unexpected response: rdata %h err %b", b3.rsp_rdata, b3.rsp_err);
      end else begin
        e3 = q3.pop_front();
        chk({"d3 ", e3.name, " rdata"}, b3.rsp_rdata, e3.rd);
        chk({"d3 ", e3.name, " err"}, 32'(b3.rsp_err), 32'(e3.err));
        chk({"d3 ", e3.name, " latency"}, 32'(cyc - e3.cyc), 32'd4);
      end
    end else chk("d3 idle outputs", b3.rsp_rdata | 32'(b3.rsp_err), 32'd0);
  end
  task automatic drv0(input logic we, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err, input string name, output int n);
    exp_t e;
    b0.req_valid = 1'b1; b0.req_we = we; b0.req_addr = addr; b0.req_funct3 = f3; b0.req_wdata = wd;
    n = 0;
    while (!b0.req_ready && n < 50) begin n++; @(negedge clk); end
    if (!b0.req_ready) begin
      checks++; errors++;
      $display("FAIL d0 %s: accept timeout, ready %b required 1", name, b0.req_ready);
    end else begin
      e.rd = rd; e.err = err; e.cyc = cyc; e.name = name;
      q0.push_back(e);
    end
    @(negedge clk);
  endtask
  task automatic drv3(input logic we, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err, input bit rsp, input string name, output int n);
    exp_t e;
    b3.req_valid = 1'b1; b3.req_we = we; b3.req_addr = addr; b3.req_funct3 = f3; b3.req_wdata = wd;
    n = 0;
    while (!b3.req_ready && n < 50) begin n++; @(negedge clk); end
    if (!b3.req_ready) begin
      checks++; errors++;
      $display("FAIL d3 %s: accept timeout, ready %b required 1", name, b3.req_ready);
    end else if (rsp) begin
      e.rd = rd; e.err = err; e.cyc = cyc; e.name = name;
      q3.push_back(e);
    end
    @(negedge clk);
  endtask
  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_funct3 = '0; b0.req_wdata = '0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = '0; b3.req_funct3 = '0; b3.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("d0 reset ready", 32'(b0.req_ready), 32'd1);
    chk("d0 reset rsp_valid", 32'(b0.rsp_valid), 32'd0);
    chk("d0 reset rdata/err", b0.rsp_rdata | 32'(b0.rsp_err), 32'd0);
    chk("d3 reset ready", 32'(b3.req_ready), 32'd1);
    chk("d3 reset rsp_valid", 32'(b3.rsp_valid), 32'd0);
    chk("d3 reset rdata/err", b3.rsp_rdata | 32'(b3.rsp_err), 32'd0);
    rst0 = 1'b0; rst3 = 1'b0; mon_on = 1'b1;
    drv0(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, "SW 10", low);
    drv0(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0, "LW 10", low);
    chk("d0 ready low cycles", 32'(low), 32'd1);
    drv0(1'b1, 32'h11, 3'd0, 32'h12345680, 32'h0, 1'b0, "SB 11", low);
    drv0(1'b0, 32'h11, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0, "LB 11", low);
    drv0(1'b0, 32'h11, 3'd4, 32'h0, 32'h00000080, 1'b0, "LBU 11", low);
    drv0(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0, "LW 10 after SB", low);
    drv0(1'b1, 32'h20, 3'd2, 32'h11223344, 32'h0, 1'b0, "SW 20", low);
    drv0(1'b1, 32'h22, 3'd1, 32'hAAAA8001, 32'h0, 1'b0, "SH 22", low);
    drv0(1'b0, 32'h22, 3'd1, 32'h0, 32'hFFFF8001, 1'b0, "LH 22", low);
    drv0(1'b0, 32'h22, 3'd5, 32'h0, 32'h00008001, 1'b0, "LHU 22", low);
    drv0(1'b0, 32'h20, 3'd1, 32'h0, 32'h00003344, 1'b0, "LH 20", low);
    drv0(1'b0, 32'h23, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0, "LB 23", low);
    drv0(1'b0, 32'h22, 3'd4, 32'h0, 32'h00000001, 1'b0, "LBU 22", low);
    drv0(1'b1, 32'hFC, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, "SW last word", low);
    drv0(1'b0, 32'hFF, 3'd0, 32'h0, 32'hFFFFFFCA, 1'b0, "LB last byte", low);
    drv0(1'b0, 32'h13, 3'd2, 32'h0, 32'h0, 1'b1, "LW misaligned", low);
    drv0(1'b0, 32'h21, 3'd1, 32'h0, 32'h0, 1'b1, "LH odd", low);
    drv0(1'b0, 32'h10, 3'd3, 32'h0, 32'h0, 1'b1, "load f3 011", low);
    drv0(1'b0, 32'h10, 3'd6, 32'h0, 32'h0, 1'b1, "load f3 110", low);
    drv0(1'b0, 32'h10, 3'd7, 32'h0, 32'h0, 1'b1, "load f3 111", low);
    drv0(1'b1, 32'h100, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, "SW past end", low);
    drv0(1'b0, 32'hFFFFFFFC, 3'd2, 32'h0, 32'h0, 1'b1, "LW top of space", low);
    drv0(1'b1, 32'h20, 3'd3, 32'hFFFFFFFF, 32'h0, 1'b1, "store f3 011", low);
    drv0(1'b1, 32'h20, 3'd4, 32'hFFFFFFFF, 32'h0, 1'b1, "store f3 100", low);
    drv0(1'b1, 32'h23, 3'd1, 32'hFFFFFFFF, 32'h0, 1'b1, "SH odd", low);
    drv0(1'b1, 32'h12, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, "SW misaligned", low);
    drv0(1'b0, 32'h20, 3'd2, 32'h0, 32'h80013344, 1'b0, "LW 20 unchanged", low);
    drv0(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0, "LW 10 unchanged", low);
    b0.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    // A store presented while reset is high must not be accepted.
    rst0 = 1'b1; b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 32'h10; b0.req_funct3 = 3'd2; b0.req_wdata = 32'h55555555;
    @(negedge clk);
    chk("d0 ready under reset", 32'(b0.req_ready), 32'd1);
    rst0 = 1'b0; b0.req_valid = 1'b0;
    @(negedge clk);
    drv0(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0, "LW 10 after reset store", low);
    b0.req_valid = 1'b0;
    drv3(1'b1, 32'h40, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, "SW 40 zero", low);
    drv3(1'b1, 32'h44, 3'd2, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, "SW 44", low);
    chk("d3 ready low cycles 1", 32'(low), 32'd4);
    drv3(1'b0, 32'h44, 3'd2, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, "LW 44", low);
    chk("d3 ready low cycles 2", 32'(low), 32'd4);
    drv3(1'b0, 32'h47, 3'd0, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1, "LB 47", low);
    chk("d3 ready low cycles 3", 32'(low), 32'd4);
    drv3(1'b0, 32'h40, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, "LW 40", low);
    chk("d3 ready low cycles 4", 32'(low), 32'd4);
    drv3(1'b1, 32'h40, 3'd2, 32'h12345678, 32'h0, 1'b0, 1'b0, "SW 40 aborted", low);
    b3.req_valid = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("d3 ready after abort", 32'(b3.req_ready), 32'd1);
    rst3 = 1'b0;
    drv3(1'b0, 32'h40, 3'd2, 32'h0, 32'h0, 1'b0, 1'b1, "LW 40 after abort", low);
    b3.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("d0 responses outstanding", 32'(q0.size()), 32'd0);
    chk("d3 responses outstanding", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
